// File: rtl/serial_rca.sv
// serial_rca: multi-cycle ripple-carry adder/subtractor, one DIGIT-bit slice per clock, LSB first
module serial_rca #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int SW = STEPS > 1 ? $clog2(STEPS) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad
      $error("serial_rca: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nxt;
  logic [SW-1:0]    step;
  logic [WIDTH-1:0] ar, br, work, wnext;
  logic             carry, cc, ctop, last;
  logic [DIGIT-1:0] sa, sb, s;

  assign last      = step == SW'(STEPS - 1);
  assign in_ready  = state == IDLE && !rst;
  assign out_valid = state == DONE;

  // ctop ends as the carry into the slice MSB, which on the last slice is bit WIDTH-1
  always_comb begin
    sa = ar[step*DIGIT +: DIGIT];
    sb = br[step*DIGIT +: DIGIT];
    s = '0;
    cc = carry;
    ctop = carry;
    for (int i = 0; i < DIGIT; i++) begin
      ctop = (i == DIGIT - 1) ? cc : ctop;
      s[i] = sa[i] ^ sb[i] ^ cc;
      cc = (sa[i] & sb[i]) | (cc & (sa[i] ^ sb[i]));
    end
    wnext = work;
    wnext[step*DIGIT +: DIGIT] = s;
  end

  always_comb begin
    nxt = state;
    nxt = (state == IDLE && in_valid) ? RUN :
          (state == RUN && last) ? DONE :
          (state == DONE && out_ready) ? IDLE : state;
  end

  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      step  <= '0;
      ar    <= '0;
      br    <= '0;
      work  <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ar    <= a;
      br    <= sub ? ~b : b;
      carry <= ci ^ sub;
      step  <= '0;
    end else if (state == RUN) begin
      work  <= wnext;
      carry <= cc;
      step  <= step + SW'(1);
      if (last) begin
        sum  <= wnext;
        cout <= cc;
        ovf  <= ctop ^ cc;
      end
    end
  end
endmodule

// File: tb/tb_serial_rca.sv
// tb_serial_rca: directed checks of the 16-bit/4-bit serial adder plus a single-step (DIGIT=16) build
module tb_serial_rca;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, out_ready = 0, in_valid2 = 0, out_ready2 = 0;
  logic [15:0] a = 0, b = 0;
  logic        ci = 0, sub = 0;
  logic        in_ready, out_valid, cout, ovf;
  logic        in_ready2, out_valid2, cout2, ovf2;
  logic [15:0] sum, sum2;
  int          errors = 0, checks = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_rca #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  serial_rca #(.WIDTH(16), .DIGIT(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a), .b(b),
    .ci(ci), .sub(sub), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2), .ovf(ovf2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    in_valid = 1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h want 0000", sum); end
    rst = 0;
    in_valid = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    tick();
  endtask

  // accepts one operation, checks 4-cycle latency and the result, then drains it
  task automatic run_op(input string name, input logic [15:0] va, input logic [15:0] vb,
                        input logic vci, input logic vsub,
                        input logic [15:0] es, input logic ec, input logic eo);
    int n;
    a = va; b = vb; ci = vci; sub = vsub; in_valid = 1; out_ready = 0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b want 1", name, in_ready); end
    tick();
    in_valid = 0; a = 16'hA5A5; b = 16'h5A5A; ci = ~vci; sub = ~vsub;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL %s_latency: got %0d want 4", name, n); end
    checks++;
    if ({sum, cout, ovf} !== {es, ec, eo})
      begin errors++; $display("FAIL %s_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", name, sum, cout, ovf, es, ec, eo); end
    out_ready = 1;
    tick();
    out_ready = 0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL %s_drain: got in_ready=%b out_valid=%b want 1 0", name, in_ready, out_valid); end
  endtask

  task automatic test_carry;
    run_op("ripple", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    run_op("negneg", 16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1);
  endtask

  task automatic test_overflow;
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    run_op("carry_in", 16'h1234, 16'h0000, 1, 0, 16'h1235, 0, 0);
  endtask

  task automatic test_subtract;
    run_op("sub_neg", 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
    run_op("sub_borrow_in", 16'h0010, 16'h0003, 1, 1, 16'h000C, 1, 0);
  endtask

  task automatic test_backpressure;
    int n;
    a = 16'h0102; b = 16'h0304; ci = 0; sub = 0; in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0406, 1'b0, 1'b0})
        begin errors++; $display("FAIL hold_%0d: got v=%b r=%b sum=%h c=%b o=%b want v=1 r=0 sum=0406 c=0 o=0", i, out_valid, in_ready, sum, cout, ovf); end
      tick();
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back;
    int t0, t1, got;
    a = 16'h0001; b = 16'h0002; ci = 0; sub = 0; in_valid = 1; out_ready = 1;
    got = 0; t0 = 0; t1 = 0;
    for (int i = 0; i < 30 && got < 2; i++) begin
      if (in_ready) begin
        if (got == 0) t0 = cyc; else t1 = cyc;
        got++;
      end
      tick();
    end
    in_valid = 0;
    checks++;
    if (got !== 2 || t1 - t0 !== 6) begin errors++; $display("FAIL b2b_spacing: got %0d accepts spacing %0d want 2 accepts spacing 6", got, t1 - t0); end
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
    checks++;
    if (sum !== 16'h0003) begin errors++; $display("FAIL b2b_sum: got %h want 0003", sum); end
    tick();
    out_ready = 0;
  endtask

  task automatic test_mid_reset;
    int seen;
    a = 16'h1111; b = 16'h2222; ci = 0; sub = 0; in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrst_no_valid: got %0d valid cycles want 0", seen); end
    checks++;
    if (sum !== 16'h0000) begin errors++; $display("FAIL midrst_sum: got %h want 0000", sum); end
  endtask

  task automatic test_single_step;
    int n;
    a = 16'h00FF; b = 16'h0F01; ci = 0; sub = 0; in_valid2 = 1; out_ready2 = 0;
    checks++;
    if (in_ready2 !== 1'b1) begin errors++; $display("FAIL d16_ready: got %b want 1", in_ready2); end
    tick();
    in_valid2 = 0; a = 0; b = 0;
    n = 0;
    while (out_valid2 !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (n !== 1) begin errors++; $display("FAIL d16_latency: got %0d want 1", n); end
    checks++;
    if ({sum2, cout2, ovf2} !== {16'h1000, 1'b0, 1'b0})
      begin errors++; $display("FAIL d16_result: got sum=%h c=%b o=%b want sum=1000 c=0 o=0", sum2, cout2, ovf2); end
    out_ready2 = 1;
    tick();
    out_ready2 = 0;
    checks++;
    if (in_ready2 !== 1'b1) begin errors++; $display("FAIL d16_drain: got %b want 1", in_ready2); end
  endtask

  initial begin
    #1;
    test_reset();
    test_carry();
    test_overflow();
    test_subtract();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_single_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
